// File: rtl/xor4_pkg.sv
// Shared types and constants for the nibble-serial XOR4 parity sequencer.
package xor4_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic int unsigned nib_count(input int unsigned word_w);
      return word_w / NIBBLE_W;
   endfunction

endpackage

// File: rtl/xor4_parity_seq_ctrl_xor4.sv
// Existing 4-input XOR component; the sequencer's only arithmetic resource.
module xor4_parity_seq_ctrl_xor4 (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   input  logic i_d,
   output logic o_f
);

   assign o_f = i_a ^ i_b ^ i_c ^ i_d;

endmodule

// File: rtl/xor4_parity_seq_ctrl.sv
// Computes word parity nibble-serially through one shared XOR4, with valid/ready
// handshakes on both the word input and the parity output.
module xor4_parity_seq_ctrl
   import xor4_pkg::*;
#(
   parameter int unsigned WORD_W     = 16,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [WORD_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_parity,
   output logic              o_busy,
   output logic [7:0]        o_word_cnt
);

   localparam int unsigned     NIB      = nib_count(WORD_W);
   localparam int unsigned     CNT_W    = $clog2(NIB + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                acc_q, acc_d;
   logic [7:0]          word_cnt_q, word_cnt_d;
   logic                xor_f;

   xor4_parity_seq_ctrl_xor4 u_xor4 (
      .i_a (shreg_q[0]),
      .i_b (shreg_q[1]),
      .i_c (shreg_q[2]),
      .i_d (shreg_q[3]),
      .o_f (xor_f)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         acc_q      <= 1'b0;
         word_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      word_cnt_d = word_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               shreg_d = i_data;
               acc_d   = PARITY_ODD;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // LSB nibble first; the nibble at cnt == LAST_CNT is the final one.
            acc_d   = acc_q ^ xor_f;
            shreg_d = shreg_q >> NIBBLE_W;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               word_cnt_d = word_cnt_q + 8'd1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only, so nothing combinational reaches back from i_ready.
   always_comb begin
      o_ready    = (state_q == IDLE);
      o_valid    = (state_q == DONE);
      o_parity   = (state_q == DONE) && acc_q;
      o_busy     = (state_q == RUN) || (state_q == DONE);
      o_word_cnt = word_cnt_q;
   end

endmodule

// File: tb/tb_xor4_parity_seq_ctrl.sv
// Scoreboard bench: three lockstep instances (16-bit even, 4-bit odd, 32-bit odd) share stimulus.
module tb_xor4_parity_seq_ctrl;

   typedef struct {
      bit par;
      int acc_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] din;
   logic [2:0]  rdy, vld, par, bsy;
   logic [7:0]  wcnt [3];

   exp_t        sb_q [3][$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   int          exp_cnt [3];
   bit  [2:0]   prev_vld = 3'b000;
   bit  [2:0]   prev_par = 3'b000;
   bit          rand_rdy = 1'b0;
   bit          end_req = 1'b0;
   bit          end_done = 1'b0;

   always #5 clk = ~clk;

   xor4_parity_seq_ctrl #(.WORD_W(16), .PARITY_ODD(1'b0)) u_dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[0]), .i_data(din[15:0]),
      .o_valid(vld[0]), .i_ready(i_ready), .o_parity(par[0]), .o_busy(bsy[0]),
      .o_word_cnt(wcnt[0])
   );
   xor4_parity_seq_ctrl #(.WORD_W(4), .PARITY_ODD(1'b1)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[1]), .i_data(din[3:0]),
      .o_valid(vld[1]), .i_ready(i_ready), .o_parity(par[1]), .o_busy(bsy[1]),
      .o_word_cnt(wcnt[1])
   );
   xor4_parity_seq_ctrl #(.WORD_W(32), .PARITY_ODD(1'b1)) u_dut32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[2]), .i_data(din),
      .o_valid(vld[2]), .i_ready(i_ready), .o_parity(par[2]), .o_busy(bsy[2]),
      .o_word_cnt(wcnt[2])
   );

   function automatic int width_of(input int d);
      return (d == 0) ? 16 : (d == 1) ? 4 : 32;
   endfunction

   function automatic bit odd_of(input int d);
      return d != 0;
   endfunction

   // Reference: count the ones in the low w bits, parity flipped for odd mode.
   function automatic bit ref_par(input logic [31:0] w, input int wd, input bit odd);
      int ones = 0;
      for (int i = 0; i < wd; i++) ones += int'(w[i]);
      return ((ones % 2) == 1) ^ odd;
   endfunction

   task automatic check(input int d, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", name, d, cyc, act, exp);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            check(d, "reset_outputs", 32'({rdy[d], vld[d], par[d], bsy[d], wcnt[d]}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
            exp_cnt[d] = 0;
         end else begin
            if (prev_vld[d] && i_ready) begin
               exp_cnt[d] = (exp_cnt[d] + 1) % 256;
               check(d, "valid_drops_after_take", 32'(vld[d]), 32'd0);
            end else if (prev_vld[d]) begin
               check(d, "valid_held", 32'(vld[d]), 32'd1);
               check(d, "parity_held", 32'(par[d]), 32'(prev_par[d]));
            end
            if (vld[d] && !prev_vld[d]) begin
               if (sb_q[d].size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_result dut%0d cyc %0d: got parity %0b, expected none",
                           d, cyc, par[d]);
               end else begin
                  e = sb_q[d].pop_front();
                  check(d, "parity", 32'(par[d]), 32'(e.par));
                  check(d, "latency", 32'(cyc - e.acc_cyc), 32'(width_of(d) / 4));
               end
            end
            check(d, "word_cnt", 32'(wcnt[d]), 32'(exp_cnt[d]));
            check(d, "ready_not_busy", 32'(rdy[d]), 32'(!bsy[d]));
            check(d, "ready_valid_excl", 32'(rdy[d] & vld[d]), 32'd0);
         end
      end
      prev_vld = vld;
      prev_par = par;
      if (end_req && !end_done) begin
         for (int d = 0; d < 3; d++) check(d, "sb_drained", 32'(sb_q[d].size()), 32'd0);
         check(0, "driver_stalls", 32'(stall_cnt), 32'd0);
         end_done = 1'b1;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (rdy != 3'b111 && n < 300) begin
         if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n++;
      end
      if (rdy != 3'b111) stall_cnt++;
   endtask

   // Called at a falling edge; the accept lands on the next rising edge.
   task automatic send(input logic [31:0] w, input bit hold);
      exp_t e;
      wait_ready();
      i_valid = 1'b1;
      din     = w;
      for (int d = 0; d < 3; d++) begin
         e.par     = ref_par(w, width_of(d), odd_of(d));
         e.acc_cyc = cyc + 1;
         sb_q[d].push_back(e);
      end
      @(negedge clk);
      if (hold) begin
         din = $urandom;
         @(negedge clk);
      end
      i_valid = 1'b0;
      din     = $urandom;
   endtask

   initial begin
      logic [31:0] basic [7];
      int n;
      basic = '{32'h0000, 32'h0001, 32'hFFFF, 32'h8001, 32'h7000, 32'h0000_0001, 32'h0000_000F};
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      din     = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (basic[i]) send(basic[i], 1'b0);

      // Backpressure: hold the result ten cycles, then release.
      wait_ready();
      i_ready = 1'b0;
      send(32'h0003, 1'b0);
      n = 0;
      while (!vld[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!vld[0]) stall_cnt++;
      repeat (10) @(negedge clk);
      i_ready = 1'b1;

      // i_valid stays high with fresh data while the word is in flight.
      send($urandom, 1'b1);
      send($urandom, 1'b1);

      // Reset during the second RUN cycle of the 16-bit instance.
      send(32'hABCD, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) sb_q[d].delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h0001, 1'b0);

      // Enough handshakes to wrap the word counter.
      repeat (256) send($urandom, 1'b0);

      rand_rdy = 1'b1;
      repeat (100) send($urandom, ($urandom_range(0, 3) == 0));
      rand_rdy = 1'b0;
      i_ready  = 1'b1;

      wait_ready();
      repeat (2) @(negedge clk);
      end_req = 1'b1;
      n = 0;
      while (!end_done && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!end_done) begin
         $display("FAIL end_check: got no final drain check, expected one");
         $fatal(1, "final check not reached");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
